// File: rtl/multicycle_control.sv
// Main controller FSM for the multicycle LEGv8 datapath: sequences
// fetch/decode/execute/memory/writeback and drives datapath controls.
//
// Ports:
//   CLK, Reset_L (sync, active low)    clock and reset
//   Opcode[10:0]                        IR bits [31:21]
//   MemReady                            memory access completes this cycle
//   PCWrite, PCWriteCond, PCSource      PC update controls
//   IRWrite, MemRead, MemWrite          IR and memory controls
//   RegWrite, MemtoReg, Reg2Loc         register file controls
//   ALUSrcA, ALUSrcB[1:0], ALUop[1:0]   ALU operand and operation selects
//   Illegal, MemTimeout                 sticky halt causes
//   Retired[31:0]                       retired-instruction count, only
//                                       when MULTICYCLE_RETIRE_CNT_EN is defined
module multicycle_control #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [10:0] Opcode,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        PCSource,
    output logic        IRWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        Reg2Loc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUop,
`ifdef MULTICYCLE_RETIRE_CNT_EN
    output logic [31:0] Retired,
`endif
    output logic        Illegal,
    output logic        MemTimeout
);

    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_R_EXEC,
        S_R_WB,
        S_ADDR,
        S_LD_MEM,
        S_LD_WB,
        S_ST_MEM,
        S_CBZ_EXEC,
        S_B_EXEC,
        S_HALT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          illegal_q, illegal_d;
    logic          tmo_q, tmo_d;

    // Opcode classes
    logic is_ldur, is_stur, is_cbz, is_b, is_r;

    always_comb begin
        is_ldur = (Opcode == 11'b11111000010);
        is_stur = (Opcode == 11'b11111000000);
        is_cbz  = (Opcode[10:3] == 8'b10110100);
        is_b    = (Opcode[10:5] == 6'b000101);
        is_r    = (Opcode == 11'b10001011000) ||
                  (Opcode == 11'b11001011000) ||
                  (Opcode == 11'b10001010000) ||
                  (Opcode == 11'b10101010000);
    end

    logic in_wait;
    logic tmo_hit;

    always_comb begin
        in_wait = (state_q == S_FETCH) ||
                  (state_q == S_LD_MEM) ||
                  (state_q == S_ST_MEM);
        // MemReady=1 in the same cycle beats the timeout.
        tmo_hit = (TIMEOUT != 0) && in_wait && !MemReady &&
                  (wait_q == CW'(TIMEOUT - 1));
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        tmo_d     = tmo_q;
        unique case (state_q)
            S_FETCH: begin
                if (MemReady) begin
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_HALT;
                    tmo_d   = 1'b1;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    is_r:              state_d = S_R_EXEC;
                    is_ldur, is_stur:  state_d = S_ADDR;
                    is_cbz:            state_d = S_CBZ_EXEC;
                    is_b:              state_d = S_B_EXEC;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_R_EXEC:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_ADDR:     state_d = is_stur ? S_ST_MEM : S_LD_MEM;
            S_LD_MEM: begin
                if (MemReady) begin
                    state_d = S_LD_WB;
                end else if (tmo_hit) begin
                    state_d = S_HALT;
                    tmo_d   = 1'b1;
                end
            end
            S_LD_WB:    state_d = S_FETCH;
            S_ST_MEM: begin
                if (MemReady) begin
                    state_d = S_FETCH;
                end else if (tmo_hit) begin
                    state_d = S_HALT;
                    tmo_d   = 1'b1;
                end
            end
            S_CBZ_EXEC: state_d = S_FETCH;
            S_B_EXEC:   state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_HALT;
        endcase
    end

    // Counter only runs while parked in one wait state with MemReady low.
    always_comb begin
        wait_d = '0;
        if (in_wait && !MemReady && (state_d == state_q)) begin
            wait_d = wait_q + CW'(1);
        end
    end

`ifdef MULTICYCLE_RETIRE_CNT_EN
    logic [31:0] retired_q, retired_d;
    logic        retire;

    always_comb begin
        retire = (state_d == S_FETCH) &&
                 ((state_q == S_R_WB) || (state_q == S_LD_WB) ||
                  (state_q == S_ST_MEM) || (state_q == S_CBZ_EXEC) ||
                  (state_q == S_B_EXEC));
        retired_d = retire ? retired_q + 32'd1 : retired_q;
    end

    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign Retired = retired_q;
`endif

    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            tmo_q     <= tmo_d;
        end
    end

    // Moore decode; IRWrite/PCWrite in FETCH follow MemReady directly.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        MemtoReg    = 1'b0;
        Reg2Loc     = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUop       = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                Reg2Loc = is_stur || is_cbz;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUop   = 2'b10;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
            end
            S_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                Reg2Loc = is_stur;
            end
            S_LD_MEM: begin
                MemRead = 1'b1;
            end
            S_LD_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_ST_MEM: begin
                MemWrite = 1'b1;
                Reg2Loc  = 1'b1;
            end
            S_CBZ_EXEC: begin
                Reg2Loc     = 1'b1;
                ALUSrcA     = 1'b1;
                ALUop       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
            end
            S_B_EXEC: begin
                PCWrite  = 1'b1;
                PCSource = 1'b1;
            end
            S_HALT: begin
            end
            default: begin
            end
        endcase
    end

    assign Illegal    = illegal_q;
    assign MemTimeout = tmo_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control vectors are
// queued as expectations and compared on the falling edge.
module tb_multicycle_control;

    logic        CLK = 1'b0;
    logic        Reset_L = 1'b0;
    logic [10:0] Opcode = 11'b0;
    logic        MemReady = 1'b1;
    logic        PCWrite, PCWriteCond, PCSource, IRWrite;
    logic        MemRead, MemWrite, RegWrite, MemtoReg;
    logic        Reg2Loc, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUop;
    logic        Illegal, MemTimeout;
`ifdef MULTICYCLE_RETIRE_CNT_EN
    logic [31:0] Retired;
`endif

    multicycle_control #(.TIMEOUT(4)) dut (
        .CLK(CLK),
        .Reset_L(Reset_L),
        .Opcode(Opcode),
        .MemReady(MemReady),
        .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond),
        .PCSource(PCSource),
        .IRWrite(IRWrite),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .RegWrite(RegWrite),
        .MemtoReg(MemtoReg),
        .Reg2Loc(Reg2Loc),
        .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB),
        .ALUop(ALUop),
`ifdef MULTICYCLE_RETIRE_CNT_EN
        .Retired(Retired),
`endif
        .Illegal(Illegal),
        .MemTimeout(MemTimeout)
    );

    always #5 CLK = ~CLK;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] OP_BAD  = 11'b11111111111;

    typedef struct {
        logic [15:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    logic [15:0] got;
    assign got = {PCWrite, PCWriteCond, PCSource, IRWrite,
                  MemRead, MemWrite, RegWrite, MemtoReg,
                  Reg2Loc, ALUSrcA, ALUSrcB, ALUop,
                  Illegal, MemTimeout};

    function automatic logic [15:0] ex(
        input logic pw, pwc, ps, iw, mr, mw, rw, mt, rl, sa,
        input logic [1:0] sbs, op,
        input logic il, tm
    );
        return {pw, pwc, ps, iw, mr, mw, rw, mt, rl, sa, sbs, op, il, tm};
    endfunction

    logic [15:0] F_RDY, F_WAIT, DEC, DEC_R2L, REX, RWB;
    logic [15:0] AD_LD, AD_ST, LDM, LDWB, STM, CBZX, BX;
    logic [15:0] HLT_I, HLT_T;

    // One clock cycle: drive MemReady, queue the expected vector,
    // compare at the falling edge, advance past the next rising edge.
    task automatic cyc(input logic mr, input logic [15:0] e,
                       input string tag);
        exp_t x;
        MemReady = mr;
        sb.push_back('{e, tag});
        @(negedge CLK);
        x = sb.pop_front();
        checks++;
        assert (got === x.v) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", x.tag, got, x.v);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic rst(input int n);
        Reset_L  = 1'b0;
        MemReady = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
        Reset_L = 1'b1;
    endtask

`ifdef MULTICYCLE_RETIRE_CNT_EN
    task automatic chk_ret(input logic [31:0] e, input string tag);
        checks++;
        assert (Retired === e) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, Retired, e);
        end
    endtask
`endif

    initial begin
        F_RDY   = ex(1,0,0,1,1,0,0,0,0,0,2'b01,2'b00,0,0);
        F_WAIT  = ex(0,0,0,0,1,0,0,0,0,0,2'b01,2'b00,0,0);
        DEC     = ex(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,0,0);
        DEC_R2L = ex(0,0,0,0,0,0,0,0,1,0,2'b11,2'b00,0,0);
        REX     = ex(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,0,0);
        RWB     = ex(0,0,0,0,0,0,1,0,0,0,2'b00,2'b00,0,0);
        AD_LD   = ex(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,0,0);
        AD_ST   = ex(0,0,0,0,0,0,0,0,1,1,2'b10,2'b00,0,0);
        LDM     = ex(0,0,0,0,1,0,0,0,0,0,2'b00,2'b00,0,0);
        LDWB    = ex(0,0,0,0,0,0,1,1,0,0,2'b00,2'b00,0,0);
        STM     = ex(0,0,0,0,0,1,0,0,1,0,2'b00,2'b00,0,0);
        CBZX    = ex(0,1,1,0,0,0,0,0,1,1,2'b00,2'b01,0,0);
        BX      = ex(1,0,1,0,0,0,0,0,0,0,2'b00,2'b00,0,0);
        HLT_I   = ex(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,1,0);
        HLT_T   = ex(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,1);

        rst(2);
`ifdef MULTICYCLE_RETIRE_CNT_EN
        chk_ret(0, "ret_reset");
`endif
        // ADD: 4 cycles
        Opcode = OP_ADD;
        cyc(1, F_RDY, "add_fetch");
        cyc(1, DEC,   "add_dec");
        cyc(1, REX,   "add_rexec");
        cyc(1, RWB,   "add_rwb");
`ifdef MULTICYCLE_RETIRE_CNT_EN
        chk_ret(1, "ret_add");
`endif
        // LDUR with 3 wait cycles: 8 cycles
        Opcode = OP_LDUR;
        cyc(1, F_RDY, "ld_fetch");
        cyc(1, DEC,   "ld_dec");
        cyc(1, AD_LD, "ld_addr");
        repeat (3) cyc(0, LDM, "ld_wait");
        cyc(1, LDM,   "ld_mem");
        cyc(1, LDWB,  "ld_wb");
        // STUR with 1 wait cycle
        Opcode = OP_STUR;
        cyc(1, F_RDY,   "st_fetch");
        cyc(1, DEC_R2L, "st_dec");
        cyc(1, AD_ST,   "st_addr");
        cyc(0, STM,     "st_wait");
        cyc(1, STM,     "st_mem");
        // CBZ then B
        Opcode = OP_CBZ;
        cyc(1, F_RDY,   "cbz_fetch");
        cyc(1, DEC_R2L, "cbz_dec");
        cyc(1, CBZX,    "cbz_exec");
        Opcode = OP_B;
        cyc(1, F_RDY, "b_fetch");
        cyc(1, DEC,   "b_dec");
        cyc(1, BX,    "b_exec");
`ifdef MULTICYCLE_RETIRE_CNT_EN
        chk_ret(5, "ret_five");
`endif
        // Reset while waiting in LD_MEM
        Opcode = OP_LDUR;
        cyc(1, F_RDY, "mid_fetch");
        cyc(1, DEC,   "mid_dec");
        cyc(1, AD_LD, "mid_addr");
        cyc(0, LDM,   "mid_wait");
        rst(1);
`ifdef MULTICYCLE_RETIRE_CNT_EN
        chk_ret(0, "ret_midrst");
`endif
        cyc(1, F_RDY, "mid_refetch");
        cyc(1, DEC,   "mid_dec2");
        cyc(1, AD_LD, "mid_addr2");
        cyc(1, LDM,   "mid_mem2");
        cyc(1, LDWB,  "mid_wb2");
        // Illegal opcode halts; MemReady is ignored in HALT
        Opcode = OP_BAD;
        cyc(1, F_RDY, "ill_fetch");
        cyc(1, DEC,   "ill_dec");
        for (int i = 0; i < 20; i++) begin
            cyc(1'($urandom_range(0, 1)), HLT_I, "ill_halt");
        end
`ifdef MULTICYCLE_RETIRE_CNT_EN
        chk_ret(1, "ret_halt");
`endif
        rst(1);
        Opcode = OP_B;
        cyc(1, F_RDY, "ill_clear");
        cyc(1, DEC,   "ill_b_dec");
        cyc(1, BX,    "ill_b_exec");
        // Fetch timeout after 4 MemReady-low cycles
        repeat (3) cyc(0, F_WAIT, "to_wait");
        cyc(0, F_WAIT, "to_last");
        cyc(0, HLT_T,  "to_halt");
        cyc(1, HLT_T,  "to_hold");
        rst(1);
        // MemReady on the 4th cycle wins over the timeout
        repeat (3) cyc(0, F_WAIT, "sv_wait");
        cyc(1, F_RDY, "sv_ready");
        cyc(1, DEC,   "sv_dec");
        cyc(1, BX,    "sv_exec");
        cyc(1, F_RDY, "sv_fetch");
`ifdef MULTICYCLE_RETIRE_CNT_EN
        chk_ret(1, "ret_final");
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
